// File: rtl/nios2_cpu_div_pkg.sv
// -----------------------------------------------------------------------------
// nios2_cpu_div_pkg
//   Shared types and constants for the Nios II execute-stage divide cell.
//   div_state_t : control FSM states (IDLE -> PREP -> ITER -> FIXUP -> IDLE)
//   DIV_DATA_W  : default operand width
//   DIV_LATENCY : cycles from an accepted start to the done pulse
//   DIV_CNT_W   : width of the iteration counter
// -----------------------------------------------------------------------------
package nios2_cpu_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PREP  = 2'd1,
    ITER  = 2'd2,
    FIXUP = 2'd3
  } div_state_t;

  localparam int DIV_DATA_W  = 32;
  localparam int DIV_LATENCY = DIV_DATA_W + 3;
  localparam int DIV_CNT_W   = $clog2(DIV_DATA_W);

endpackage

// File: rtl/nios2_cpu_div_step.sv
// -----------------------------------------------------------------------------
// nios2_cpu_div_step
//   One combinational restoring-division step.
//   Ports:
//     rem      in   DATA_W  partial remainder (always < dvs when dvs != 0)
//     dvd_msb  in   1       next dividend bit shifted into the remainder
//     dvs      in   DATA_W  divisor magnitude
//     rem_next out  DATA_W  partial remainder after this step
//     q_bit    out  1       quotient bit produced by this step
// -----------------------------------------------------------------------------
module nios2_cpu_div_step
  import nios2_cpu_div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic [DATA_W-1:0] rem,
  input  logic              dvd_msb,
  input  logic [DATA_W-1:0] dvs,
  output logic [DATA_W-1:0] rem_next,
  output logic              q_bit
);

  // Two guard bits: one for the shifted-in bit, one for the borrow.
  logic [DATA_W+1:0] shifted;
  logic [DATA_W+1:0] diff;
  logic              unused_hi;

  always_comb begin
    shifted  = {1'b0, rem, dvd_msb};
    diff     = shifted - {2'b00, dvs};
    q_bit    = ~diff[DATA_W+1];
    // A kept difference is below dvs, a restored value is below dvs as well,
    // so both fit in DATA_W bits; the upper guard bits are only needed for the
    // sign test (or are don't-care when dividing by zero).
    rem_next = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
  end

  assign unused_hi = ^{diff[DATA_W], shifted[DATA_W+1:DATA_W]};

endmodule

// File: rtl/nios2_cpu_div_cell.sv
// -----------------------------------------------------------------------------
// nios2_cpu_div_cell
//   Iterative radix-2 restoring divider for Nios II div/divu. Quotient and
//   remainder appear DATA_W+3 cycles after an accepted start; the CPU stalls
//   on div_busy.
//   Ports:
//     clk            in   1       rising-edge clock
//     reset          in   1       asynchronous active-high reset
//     E_src1         in   DATA_W  dividend, sampled on accepted start
//     E_src2         in   DATA_W  divisor, sampled on accepted start
//     E_div_signed   in   1       1 = div (signed), 0 = divu
//     E_div_start    in   1       start request, honoured when div_ready
//     E_div_abort    in   1       pipeline flush, kills an in-flight op
//     div_ready      out  1       can accept a start this cycle
//     div_busy       out  1       operation in flight
//     div_done       out  1       one-cycle pulse, results valid
//     div_by_zero    out  1       completed op had a zero divisor
//     div_quotient   out  DATA_W  quotient, held until the next completion
//     div_remainder  out  DATA_W  remainder, held until the next completion
// -----------------------------------------------------------------------------
module nios2_cpu_div_cell
  import nios2_cpu_div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] E_src1,
  input  logic [DATA_W-1:0] E_src2,
  input  logic              E_div_signed,
  input  logic              E_div_start,
  input  logic              E_div_abort,
  output logic              div_ready,
  output logic              div_busy,
  output logic              div_done,
  output logic              div_by_zero,
  output logic [DATA_W-1:0] div_quotient,
  output logic [DATA_W-1:0] div_remainder
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  // Magnitude of a two's-complement operand; raw value in unsigned mode.
  // |MIN| is representable as an unsigned DATA_W value, so no saturation.
  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v,
                                            input logic                     is_signed);
    logic [DATA_W-1:0] u;
    u = v;
    if (is_signed && u[DATA_W-1]) begin
      mag = ~u + 1'b1;
    end else begin
      mag = u;
    end
  endfunction

  // Conditional two's-complement negation for the final sign fixup.
  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v,
                                               input logic              neg);
    if (neg) begin
      neg_if = ~v + 1'b1;
    end else begin
      neg_if = v;
    end
  endfunction

  div_state_t              state;

  logic signed [DATA_W-1:0] src1_p0;
  logic signed [DATA_W-1:0] src2_p0;
  logic                     sgn_p0;

  logic [DATA_W-1:0]        dvd_p1;
  logic [DATA_W-1:0]        dvs_p1;
  logic [DATA_W-1:0]        rem_p1;
  logic [DATA_W-1:0]        quo_p1;
  logic [CNT_W-1:0]         cnt_p1;
  logic                     q_neg_p1;
  logic                     r_neg_p1;
  logic                     dz_p1;

  logic [DATA_W-1:0]        rem_next;
  logic                     q_bit;

  nios2_cpu_div_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .rem      (rem_p1),
    .dvd_msb  (dvd_p1[DATA_W-1]),
    .dvs      (dvs_p1),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  assign div_ready = (state == IDLE);
  assign div_busy  = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      div_done      <= 1'b0;
      div_by_zero   <= 1'b0;
      div_quotient  <= '0;
      div_remainder <= '0;
      src1_p0       <= '0;
      src2_p0       <= '0;
      sgn_p0        <= 1'b0;
      dvd_p1        <= '0;
      dvs_p1        <= '0;
      rem_p1        <= '0;
      quo_p1        <= '0;
      cnt_p1        <= '0;
      q_neg_p1      <= 1'b0;
      r_neg_p1      <= 1'b0;
      dz_p1         <= 1'b0;
    end else begin
      div_done <= 1'b0;
      // A flush wins over everything, including a start presented in IDLE.
      if (E_div_abort) begin
        state <= IDLE;
      end else begin
        case (state)
          // ---- stage p0: capture operands and mode ----
          IDLE: begin
            if (E_div_start) begin
              src1_p0 <= E_src1;
              src2_p0 <= E_src2;
              sgn_p0  <= E_div_signed;
              state   <= PREP;
            end
          end
          // ---- stage p1: magnitudes, result signs, clear datapath ----
          PREP: begin
            dvd_p1   <= mag(src1_p0, sgn_p0);
            dvs_p1   <= mag(src2_p0, sgn_p0);
            q_neg_p1 <= sgn_p0 & (src1_p0[DATA_W-1] ^ src2_p0[DATA_W-1]);
            r_neg_p1 <= sgn_p0 & src1_p0[DATA_W-1];
            dz_p1    <= (src2_p0 == '0);
            rem_p1   <= '0;
            quo_p1   <= '0;
            cnt_p1   <= '0;
            state    <= ITER;
          end
          ITER: begin
            rem_p1 <= rem_next;
            quo_p1 <= {quo_p1[DATA_W-2:0], q_bit};
            dvd_p1 <= {dvd_p1[DATA_W-2:0], 1'b0};
            cnt_p1 <= cnt_p1 + 1'b1;
            if (cnt_p1 == LAST_STEP) begin
              state <= FIXUP;
            end
          end
          // ---- stage p2: sign fixup and result registers ----
          FIXUP: begin
            if (dz_p1) begin
              // Zero divisor: fixed pattern, dividend passed through untouched.
              div_quotient  <= '1;
              div_remainder <= src1_p0;
            end else begin
              div_quotient  <= neg_if(quo_p1, q_neg_p1);
              div_remainder <= neg_if(rem_p1, r_neg_p1);
            end
            div_by_zero <= dz_p1;
            div_done    <= 1'b1;
            state       <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nios2_cpu_div_cell.sv
module tb_nios2_cpu_div_cell;
  import nios2_cpu_div_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  src1, src2;
  logic          sgn, start, abort;
  logic          div_ready, div_busy, div_done, div_by_zero;
  logic [W-1:0]  div_quotient, div_remainder;

  always #5 clk = ~clk;

  nios2_cpu_div_cell #(.DATA_W(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .E_src1        (src1),
    .E_src2        (src2),
    .E_div_signed  (sgn),
    .E_div_start   (start),
    .E_div_abort   (abort),
    .div_ready     (div_ready),
    .div_busy      (div_busy),
    .div_done      (div_done),
    .div_by_zero   (div_by_zero),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder)
  );

  typedef struct {
    logic [W-1:0] s1;
    logic [W-1:0] s2;
    logic         sg;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  vec_t vecs [11];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; start is sampled by the following posedge (cycle 0).
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg);
    src1  = a;
    src2  = b;
    sgn   = sg;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Observe cycles 1.. after acceptance; optionally present a start while busy.
  task automatic wait_done(input int poke_c, output int lat, output int busy_err);
    lat      = -1;
    busy_err = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (div_busy !== (c <= W + 2)) busy_err++;
      if (div_ready !== (c > W + 2)) busy_err++;
      if (div_done === 1'b1) begin
        lat = c;
        break;
      end
      if (c == poke_c) begin
        start = 1'b1;
        src1  = 32'd999;
        src2  = 32'd3;
        sgn   = 1'b0;
      end else if (c == poke_c + 1) begin
        start = 1'b0;
      end
    end
  endtask

  task automatic watch_no_done(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (div_done === 1'b1) seen++;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat, be;
    issue(v.s1, v.s2, v.sg);
    wait_done(-1, lat, be);
    check($sformatf("v%0d_latency", idx), 32'(lat), 32'(DIV_LATENCY));
    check($sformatf("v%0d_busy", idx), 32'(be), 32'd0);
    check($sformatf("v%0d_quot", idx), div_quotient, v.q);
    check($sformatf("v%0d_rem", idx), div_remainder, v.r);
    check($sformatf("v%0d_dz", idx), {31'd0, div_by_zero}, {31'd0, v.dz});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, be;

    vecs[0]  = '{32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        1'b0};
    vecs[1]  = '{32'hFFFFFFF9, 32'h00000002, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{32'h00000007, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'h00000001, 1'b0};
    vecs[3]  = '{32'h00001234, 32'h00000000, 1'b0, 32'hFFFFFFFF, 32'h00001234, 1'b1};
    vecs[4]  = '{32'hFFFFFFFB, 32'h00000000, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1};
    vecs[5]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h00000000, 1'b0};
    vecs[6]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[7]  = '{32'hFFFFFFF9, 32'h00000002, 1'b0, 32'h7FFFFFFC, 32'h00000001, 1'b0};
    vecs[8]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'h0000000E, 32'hFFFFFFFE, 1'b0};
    vecs[9]  = '{32'd5,        32'd9,        1'b0, 32'd0,        32'd5,        1'b0};
    vecs[10] = '{32'hFFFFFFFF, 32'h80000000, 1'b1, 32'h00000000, 32'hFFFFFFFF, 1'b0};

    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    src1  = '0;
    src2  = '0;
    sgn   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, div_ready},   32'd1);
    check("rst_busy",  {31'd0, div_busy},    32'd0);
    check("rst_done",  {31'd0, div_done},    32'd0);
    check("rst_dz",    {31'd0, div_by_zero}, 32'd0);
    check("rst_quot",  div_quotient,  32'd0);
    check("rst_rem",   div_remainder, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Table-driven vectors
    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i], i);
      @(negedge clk);
      check($sformatf("v%0d_done_single", i), {31'd0, div_done}, 32'd0);
    end

    // Back-to-back: op B started in op A's done cycle
    issue(32'd100, 32'd7, 1'b0);
    wait_done(-1, lat, be);
    check("b2b_a_latency", 32'(lat), 32'(DIV_LATENCY));
    check("b2b_a_quot", div_quotient, 32'd14);
    issue(32'd1000, 32'd10, 1'b0);
    wait_done(-1, lat, be);
    check("b2b_b_latency", 32'(lat), 32'(DIV_LATENCY));
    check("b2b_b_busy", 32'(be), 32'd0);
    check("b2b_b_quot", div_quotient, 32'd100);
    check("b2b_b_rem", div_remainder, 32'd0);
    @(negedge clk);

    // Start while busy is ignored and not queued
    issue(32'hFFFFFFF9, 32'h2, 1'b1);
    wait_done(10, lat, be);
    check("poke_latency", 32'(lat), 32'(DIV_LATENCY));
    check("poke_busy", 32'(be), 32'd0);
    check("poke_quot", div_quotient, 32'hFFFFFFFD);
    check("poke_rem", div_remainder, 32'hFFFFFFFF);
    @(negedge clk);
    check("poke_not_queued", {31'd0, div_busy}, 32'd0);

    // Abort at ITER count 10 (cycle 12)
    issue(32'd100, 32'd7, 1'b0);
    repeat (12) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_ready", {31'd0, div_ready}, 32'd1);
    check("abort_busy", {31'd0, div_busy}, 32'd0);
    watch_no_done("abort_no_done", 45);
    check("abort_quot_held", div_quotient, 32'hFFFFFFFD);
    check("abort_rem_held", div_remainder, 32'hFFFFFFFF);

    // Abort together with start in IDLE drops the start
    src1  = 32'd50;
    src2  = 32'd5;
    sgn   = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_dropped", {31'd0, div_busy}, 32'd0);

    // Async reset at ITER count 5 (cycle 7)
    issue(32'd100, 32'd7, 1'b0);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_quot", div_quotient, 32'd0);
    check("midrst_rem", div_remainder, 32'd0);
    check("midrst_busy", {31'd0, div_busy}, 32'd0);
    check("midrst_ready", {31'd0, div_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    watch_no_done("midrst_no_done", 45);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
